serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, LSB-first two's-complement subtractor computing `a - b` one bit per clock with a single registered borrow flip-flop. It is the subtracting counterpart of the ripple adder datapath: a half-subtractor pair plus a borrow register replaces WIDTH full-subtractor stages. It is used where area matters more than latency. A start/done handshake frames each operation; the result is held stable until the next accepted start.

## Interface
- `WIDTH`, default 8, operand and result width in bits (≥2).

- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; samples `a`/`b` when accepted.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse, result valid.
- `diff` output WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow_out` output 1: final borrow; 1 iff unsigned `a < b`.

## Operation
- Reset values (`rst_n` low, asynchronous):
  - outputs: `busy`=0, `done`=0, `diff`=0, `borrow_out`=0.
  - internal: state=IDLE; operand shift registers, borrow flip-flop and bit counter all 0.
- States: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - load `a`→A shift register, `b`→B shift register, borrow=0, counter=0.
  - go to RUN.
- IDLE, `start`=0: stay in IDLE.
- RUN, each cycle, on `a0`=A[0], `b0`=B[0], `bin`=borrow:
  - `d` = `a0 ^ b0 ^ bin`.
  - `bout` = (`~a0 & b0`) | (`~(a0 ^ b0) & bin`); equivalent to two half subtractors whose borrows are ORed.
  - A and B shift right by one.
  - `d` shifts into the MSB of the result shift register.
  - borrow ← `bout`; counter increments.
- RUN, counter = WIDTH-1 on this edge:
  - last bit processed.
  - `diff` ← completed result register.
  - `borrow_out` ← final `bout`.
  - go to DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `start`=1 is accepted exactly as in IDLE (back-to-back operation, goes to RUN).
  - otherwise go to IDLE.
- `start` during RUN is ignored; it has no effect on the operands or the result.
- `diff`/`borrow_out` change only on the final RUN edge; they hold their values through IDLE and during the next RUN.
- Counter width is $clog2(WIDTH); it is reset to 0 on every accepted start, never wraps in use.
- Signed interpretation: overflow is not flagged; the user derives it from the operand and `diff` MSBs.

## Timing
- `start` sampled at edge E0 → RUN occupies cycles after edges E0..E(WIDTH-1).
- `done`=1 and new `diff` visible after edge E(WIDTH).
- Latency from start sample to `done` is WIDTH cycles.
- Throughput is one operation per WIDTH+1 cycles when `start` is asserted in DONE.
- `busy` is high for exactly WIDTH cycles per operation; `busy` and `done` are never both high.
- `a`/`b` need to be valid only in the cycle `start` is accepted.
- Reset asserted mid-RUN: immediate return to the reset values listed above; the partial result is discarded and no `done` pulse is produced. Operation resumes from IDLE on the first edge after `rst_n` rises.

## Test plan
- WIDTH=8, `a`=100, `b`=37, single-cycle start → `busy` high 8 cycles, `done` pulse after 8 cycles, `diff`=63, `borrow_out`=0.
- `a`=5, `b`=9 → `diff`=8'hFC, `borrow_out`=1. `a`=0, `b`=255 → `diff`=1, `borrow_out`=1. `a`=`b`=0 → `diff`=0, `borrow_out`=0.
- Start `a`=200, `b`=55. Pulse `start` with `a`=1, `b`=2 in the 3rd RUN cycle → ignored; result `diff`=145, `borrow_out`=0.
- Back-to-back: hold `start` high, 10−3 then 3−10 → `done` pulses 9 cycles apart; results 7/0 then 8'hF9/1. `busy` low only during the DONE cycles.
- Assert `rst_n` low in the 4th RUN cycle → all outputs 0 immediately, no `done`. After release, 50−20 → `diff`=30 after 8 cycles.
- Random regression (WIDTH=8 and WIDTH=16, ≥1000 ops): `diff` == `(a-b) mod 2^WIDTH`, `borrow_out` == (`a<b`), `done` exactly WIDTH cycles after accepted start.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start request with operands in,
// busy/done status and the registered result out.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first a - b with one borrow flop; WIDTH cycles from accepted start to done.
// No backpressure: start is taken in IDLE or DONE and ignored in RUN; result holds until the next op completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_subtractor_if.slave    sub_if
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_nxt;

    assign w_a0      = r_a[0];
    assign w_b0      = r_b[0];
    assign w_d       = w_a0 ^ w_b0 ^ r_borrow;
    // Two half subtractors: borrow from a0-b0, then from that difference minus the borrow-in.
    assign w_bout    = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
    assign w_last    = (r_cnt == LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (sub_if.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_a      <= sub_if.a;
            r_b      <= sub_if.b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_res    <= w_res_nxt;
            r_borrow <= w_bout;
            if (w_last) begin
                r_diff <= w_res_nxt;
                r_bout <= w_bout;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

    assign sub_if.busy       = (r_state == S_RUN);
    assign sub_if.done       = (r_state == S_DONE);
    assign sub_if.diff       = r_diff;
    assign sub_if.borrow_out = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Checks the serial subtractor at WIDTH=8 (directed table, corner sequences, random)
// and WIDTH=16 (random) against plain-arithmetic expected results.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(16)) if16 ();

    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .sub_if(if8));
    serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .sub_if(if16));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit w16, input logic s, input logic [15:0] av, input logic [15:0] bv);
        if (w16) begin
            if16.start = s; if16.a = av; if16.b = bv;
        end else begin
            if8.start = s; if8.a = av[7:0]; if8.b = bv[7:0];
        end
    endtask

    function automatic logic get_busy(input bit w16);
        return w16 ? if16.busy : if8.busy;
    endfunction
    function automatic logic get_done(input bit w16);
        return w16 ? if16.done : if8.done;
    endfunction
    function automatic logic [15:0] get_diff(input bit w16);
        return w16 ? if16.diff : {8'h00, if8.diff};
    endfunction
    function automatic logic get_bout(input bit w16);
        return w16 ? if16.borrow_out : if8.borrow_out;
    endfunction

    // Drives start for one cycle and waits (bounded) for done; lat is cycles after the sampling edge.
    task automatic run_op(input bit w16, input logic [15:0] av, input logic [15:0] bv,
                          output logic [15:0] d, output logic bo,
                          output int lat, output int bcnt, output int both);
        d = '0; bo = 1'b0; lat = -1; bcnt = 0; both = 0;
        set_in(w16, 1'b1, av, bv);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) set_in(w16, 1'b0, 16'h0, 16'h0);
            if (get_busy(w16)) bcnt++;
            if (get_busy(w16) && get_done(w16)) both++;
            if (get_done(w16)) begin
                lat = n;
                d   = get_diff(w16);
                bo  = get_bout(w16);
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        logic [15:0] d, d1, d2;
        logic        bo, b1, b2;
        int          lat, bcnt, both, t1, t2, bad, ndone;

        vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
        vecs[1] = '{8'd5,   8'd9,   8'hFC,  1'b1};
        vecs[2] = '{8'd0,   8'd255, 8'd1,   1'b1};
        vecs[3] = '{8'd0,   8'd0,   8'd0,   1'b0};
        vecs[4] = '{8'd255, 8'd0,   8'd255, 1'b0};
        vecs[5] = '{8'd128, 8'd1,   8'd127, 1'b0};
        vecs[6] = '{8'd127, 8'd128, 8'hFF,  1'b1};
        vecs[7] = '{8'd77,  8'd77,  8'd0,   1'b0};

        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 16'h0, 16'h0);
        set_in(1'b1, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, if8.busy}, 32'd0);
        check("reset_done", {31'b0, if8.done}, 32'd0);
        check("reset_diff", {24'b0, if8.diff}, 32'd0);
        check("reset_bout", {31'b0, if8.borrow_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, {8'h0, vecs[i].a}, {8'h0, vecs[i].b}, d, bo, lat, bcnt, both);
            check($sformatf("tbl%0d_diff", i), {16'b0, d}, {24'b0, vecs[i].exp_diff});
            check($sformatf("tbl%0d_bout", i), {31'b0, bo}, {31'b0, vecs[i].exp_bout});
            check($sformatf("tbl%0d_lat", i), lat, 32'd8);
            check($sformatf("tbl%0d_busy", i), bcnt, 32'd8);
            check($sformatf("tbl%0d_overlap", i), both, 32'd0);
            @(negedge clk);
            check($sformatf("tbl%0d_done_pulse", i), {31'b0, if8.done}, 32'd0);
        end

        // start pulsed during RUN must not disturb the running operation
        set_in(1'b0, 1'b1, 16'd200, 16'd55);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) set_in(1'b0, 1'b0, 16'h0, 16'h0);
            if (n == 2) set_in(1'b0, 1'b1, 16'd1, 16'd2);
            if (n == 3) set_in(1'b0, 1'b0, 16'h0, 16'h0);
            if (if8.done) begin lat = n; break; end
        end
        check("ignore_lat", lat, 32'd8);
        check("ignore_diff", {24'b0, if8.diff}, 32'd145);
        check("ignore_bout", {31'b0, if8.borrow_out}, 32'd0);
        @(negedge clk);

        // back-to-back with start held high
        set_in(1'b0, 1'b1, 16'd10, 16'd3);
        t1 = -1; t2 = -1; bad = 0; d1 = '0; d2 = '0; b1 = 1'b0; b2 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) set_in(1'b0, 1'b1, 16'd3, 16'd10);
            if (if8.busy == if8.done) bad++;
            if (if8.done) begin
                if (t1 < 0) begin
                    t1 = n; d1 = {8'h0, if8.diff}; b1 = if8.borrow_out;
                end else begin
                    t2 = n; d2 = {8'h0, if8.diff}; b2 = if8.borrow_out;
                    set_in(1'b0, 1'b0, 16'h0, 16'h0);
                    break;
                end
            end
        end
        check("b2b_first_lat", t1, 32'd8);
        check("b2b_spacing", t2 - t1, 32'd9);
        check("b2b_diff1", {16'b0, d1}, 32'd7);
        check("b2b_bout1", {31'b0, b1}, 32'd0);
        check("b2b_diff2", {16'b0, d2}, 32'hF9);
        check("b2b_bout2", {31'b0, b2}, 32'd1);
        check("b2b_busy_gap", bad, 32'd0);
        @(negedge clk);
        check("b2b_idle", {30'b0, if8.busy, if8.done}, 32'd0);

        // asynchronous reset in the 4th RUN cycle
        set_in(1'b0, 1'b1, 16'd100, 16'd37);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n == 0) set_in(1'b0, 1'b0, 16'h0, 16'h0);
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'b0, if8.busy}, 32'd0);
        check("rst_mid_done", {31'b0, if8.done}, 32'd0);
        check("rst_mid_diff", {24'b0, if8.diff}, 32'd0);
        check("rst_mid_bout", {31'b0, if8.borrow_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (if8.done || if8.busy) ndone++;
        end
        check("rst_no_done", ndone, 32'd0);
        run_op(1'b0, 16'd50, 16'd20, d, bo, lat, bcnt, both);
        check("rst_after_diff", {16'b0, d}, 32'd30);
        check("rst_after_lat", lat, 32'd8);

        // random regression against plain modular arithmetic, both widths
        for (int w = 0; w < 2; w++) begin
            automatic bit w16  = (w == 1);
            automatic int mask = w16 ? 32'hFFFF : 32'hFF;
            automatic int wid  = w16 ? 16 : 8;
            for (int k = 0; k < 1000; k++) begin
                automatic int ai = $urandom & mask;
                automatic int bi = $urandom & mask;
                if ((k % 97) == 0) bi = ai;
                run_op(w16, ai[15:0], bi[15:0], d, bo, lat, bcnt, both);
                check($sformatf("rnd_w%0d_diff %0h-%0h", wid, ai, bi), {16'b0, d}, (ai - bi) & mask);
                check($sformatf("rnd_w%0d_bout %0h-%0h", wid, ai, bi), {31'b0, bo}, (ai < bi) ? 32'd1 : 32'd0);
                check($sformatf("rnd_w%0d_lat", wid), lat, wid);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
